axi4_read_arbiter_n: RTL and testbench

//  N-channel read arbiter plus single-outstanding memory read engine. Collects read requests from
//  NUM_CH clients (IFU, LSU, DMA, ...), grants one at a time by round-robin, issues it to the memory

---
 rtl/axi4_read_arbiter_n.sv | 136 +++++++++++++
 tb/tb_axi4_read_arbiter_n.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_read_arbiter_n.sv
// Round-robin read arbiter over NUM_CH clients feeding a single-outstanding memory read engine.
// Latches the winner's address, times out a silent memory, and holds each client's last read data.
module axi4_read_arbiter_n #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int TIMEOUT  = 256,
  parameter int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        ch_err,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_valid,
  input  logic [DATA_W-1:0]        mem_data,
  output logic [NUM_CH-1:0]        grant,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CH_IDX_W-1:0] LAST_CH  = CH_IDX_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0]   ONE_HOT0 = {{(NUM_CH - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [CH_IDX_W-1:0]        rr_q, rr_d;
  logic [CH_IDX_W-1:0]        g_q, g_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic                       err_q, err_d;
  logic [NUM_CH*DATA_W-1:0]   data_q, data_d;

  logic                       pick_found;
  logic [CH_IDX_W-1:0]        pick_idx;
  logic [CH_IDX_W-1:0]        cand;
  logic [NUM_CH-1:0]          sel_oh;

  // Client handshake: a client raises ch_req (level) and holds it until its one-cycle
  // ch_done; the address is consumed only in the grant cycle, and ch_err qualifies ch_done.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_IDX_W'((int'(rr_q) + k) % NUM_CH);
      if (!pick_found && ch_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    addr_d  = addr_q;
    timer_d = timer_q;
    err_d   = err_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          g_d     = pick_idx;
          addr_d  = ch_addr[pick_idx*ADDR_W +: ADDR_W];
          timer_d = '0;
          err_d   = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // A data beat arriving on the last allowed cycle still counts as success.
        if (mem_valid) begin
          data_d[g_q*DATA_W +: DATA_W] = mem_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (TIMEOUT != 0 && timer_q == TMR_LAST) begin
          data_d[g_q*DATA_W +: DATA_W] = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (timer_q != {TMR_W{1'b1}}) begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        rr_d    = (g_q == LAST_CH) ? '0 : g_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      addr_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Every control output decodes registered state only, so nothing leaks from inputs.
  assign sel_oh    = ONE_HOT0 << g_q;
  assign busy      = (state_q != S_IDLE);
  assign mem_req   = (state_q == S_BUSY);
  assign grant     = busy ? sel_oh : '0;
  assign ch_done   = (state_q == S_RESP) ? sel_oh : '0;
  assign ch_err    = (state_q == S_RESP && err_q) ? sel_oh : '0;
  assign mem_addr  = addr_q;
  assign ch_data   = data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi4_read_arbiter_n.sv
// Bench for axi4_read_arbiter_n: directed scenarios plus randomized clients and memory,
// checked every cycle against a transaction-level model and an ordered expectation queue.
module tb_axi4_read_arbiter_n;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      ch_req;
  logic [N*AW-1:0]   ch_addr;
  logic [N-1:0]      ch_done;
  logic [N-1:0]      ch_err;
  logic [N*DW-1:0]   ch_data;
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic              mem_valid;
  logic [DW-1:0]     mem_data;
  logic [N-1:0]      grant;
  logic              busy;
  logic [1:0]        dbg_state;

  axi4_read_arbiter_n #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .CLK(clk), .RST(rst), .ch_req(ch_req), .ch_addr(ch_addr),
    .ch_done(ch_done), .ch_err(ch_err), .ch_data(ch_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .grant(grant), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters and scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];
  int done_t[$];
  int done_cnt[N];
  int err_cnt[N];
  int wait_cnt[N];
  int obs_idx;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int total_done();
    int s = 0;
    for (int i = 0; i < N; i++) s += done_cnt[i];
    return s;
  endfunction

  // ---------------- transaction-level model ----------------
  bit             m_active;   // waiting on memory
  bit             m_resp;     // completion being reported this cycle
  bit             m_err;
  int             m_ch;
  int             m_elapsed;
  int             m_rr;       // channel with highest priority next
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_data[N];

  task automatic model_reset();
    m_active = 0; m_resp = 0; m_err = 0; m_ch = 0; m_elapsed = 0; m_rr = 0; m_addr = '0;
    for (int i = 0; i < N; i++) m_data[i] = '0;
  endtask

  task automatic compare_outputs();
    logic [N-1:0]    e_grant, e_done, e_err;
    logic [N*DW-1:0] e_data;
    e_grant = '0;
    if (m_active || m_resp) e_grant[m_ch] = 1'b1;
    e_done = m_resp ? e_grant : '0;
    e_err  = (m_resp && m_err) ? e_grant : '0;
    for (int i = 0; i < N; i++) e_data[i*DW +: DW] = m_data[i];
    check("busy", busy, m_active || m_resp);
    check("mem_req", mem_req, m_active);
    check("grant", grant, e_grant);
    check("mem_addr", mem_addr, m_addr);
    check("ch_done", ch_done, e_done);
    check("ch_err", ch_err, e_err);
    check("ch_data", ch_data, e_data);
    check("state_legal", dbg_state != 2'd3, 1'b1);
  endtask

  // Advance one cycle using the inputs the DUT will sample at the next rising edge.
  task automatic model_step();
    int best;
    if (m_resp) begin
      m_resp = 0;
      m_rr   = (m_ch + 1) % N;
    end else if (m_active) begin
      if (mem_valid) begin
        m_data[m_ch] = mem_data; m_err = 0; m_active = 0; m_resp = 1;
      end else if (m_elapsed == TO - 1) begin
        m_data[m_ch] = '0; m_err = 1; m_active = 0; m_resp = 1;
      end else begin
        m_elapsed++;
      end
    end else begin
      best = -1;
      for (int k = 0; k < N; k++)
        if (best < 0 && ch_req[(m_rr + k) % N]) best = (m_rr + k) % N;
      if (best >= 0) begin
        m_active = 1; m_ch = best; m_addr = ch_addr[best*AW +: AW]; m_elapsed = 0;
      end
    end
  endtask

  // ---------------- compare process (falling edge) ----------------
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      compare_outputs();
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      compare_outputs();
      if (ch_done != '0) begin
        obs_idx = oh2idx(ch_done);
        done_cnt[obs_idx]++;
        if (ch_err[obs_idx]) err_cnt[obs_idx]++;
        done_t.push_back(cyc);
        if (exp_q.size() != 0) check("sb_order", obs_idx, exp_q.pop_front());
      end
      for (int i = 0; i < N; i++) begin
        if (ch_done[i]) begin
          check("fairness", wait_cnt[i] <= N - 1, 1'b1);
          wait_cnt[i] = 0;
        end else if (!ch_req[i]) begin
          wait_cnt[i] = 0;
        end else if (ch_done != '0) begin
          wait_cnt[i]++;
        end
      end
      model_step();
    end
  end

  // ---------------- driver ----------------
  int          resp_mode   = 0;   // 0 quiet, 1 fixed latency, 2 random, 3 manual
  int          resp_lat    = 0;   // -1 never answers
  int          busy_seen   = 0;
  int          vprob       = 0;
  logic [DW-1:0] resp_base = '0;
  int          client_mode = 0;   // 0 hold, 1 drop on done, 2 random

  task automatic tick();
    @(posedge clk);
    #1;
    case (resp_mode)
      0: mem_valid = 1'b0;
      1: begin
        if (mem_req) busy_seen++; else busy_seen = 0;
        mem_valid = mem_req && (busy_seen == resp_lat + 1);
        mem_data  = resp_base + DW'(oh2idx(grant));
      end
      2: begin
        mem_valid = ($urandom_range(0, 99) < vprob);
        mem_data  = $urandom;
      end
      default: ;
    endcase
    if (client_mode == 1) begin
      ch_req = ch_req & ~ch_done;
    end else if (client_mode == 2) begin
      for (int i = 0; i < N; i++) begin
        if (ch_done[i])            ch_req[i] = ($urandom_range(0, 2) == 0);
        else if (!ch_req[i])       ch_req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 63) == 0) ch_req[i] = 1'b0;
        if ($urandom_range(0, 3) == 0) ch_addr[i*AW +: AW] = $urandom;
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
    end
  endtask

  task automatic wait_sb(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic int last_done();
    return (done_t.size() > 0) ? done_t[done_t.size()-1] : -1;
  endfunction

  int t0;
  int nb;
  int vp[3] = '{30, 4, 60};

  initial begin
    rst = 1'b1; ch_req = '0; ch_addr = '0; mem_valid = 1'b0; mem_data = '0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_grant", grant, 4'b0000);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_ch_data", ch_data, 128'h0);
    check("rst_ch_done", ch_done, 4'b0000);
    rst = 1'b0;

    // Single request on ch0, memory answers in the third BUSY cycle.
    resp_mode = 1; resp_lat = 2; resp_base = 32'hDEAD; client_mode = 1;
    ch_addr[0 +: AW] = 32'h8000_0000;
    ch_req = 4'b0001;
    exp_q.push_back(4'd0);
    tick();
    check("t1_mem_req", mem_req, 1'b1);
    check("t1_mem_addr", mem_addr, 32'h8000_0000);
    check("t1_grant", grant, 4'b0001);
    wait_sb("t1_drain", 20);
    check("t1_data0", ch_data[0 +: DW], 32'hDEAD);
    check("t1_done_cnt", done_cnt[0], 1);
    check("t1_err_cnt", err_cnt[0], 0);
    check("t1_busy_back", busy, 1'b0);

    // All four requesting from reset: order 0,1,2,3,0 with a completion every 4 cycles.
    pulse_reset();
    resp_lat = 1; resp_base = 32'h1000; client_mode = 0;
    done_t.delete();
    t0 = cyc;
    ch_req = 4'b1111;
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    exp_q.push_back(4'd3); exp_q.push_back(4'd0);
    wait_sb("t2_drain", 40);
    ch_req = 4'b0000;
    for (int i = 0; i < N; i++) check("t2_data", ch_data[i*DW +: DW], 32'h1000 + i);
    check("t2_done_count", done_t.size(), 5);
    check("t2_first_latency", (done_t.size() > 0) ? done_t[0] - t0 : -1, 3);
    for (int k = 0; k + 1 < done_t.size(); k++)
      check("t2_spacing", done_t[k+1] - done_t[k], 4);

    // Silent memory on ch2 times out after TO BUSY cycles and clears its data.
    resp_lat = -1; client_mode = 1;
    done_t.delete();
    t0 = cyc;
    ch_req = 4'b0100;
    exp_q.push_back(4'd2);
    wait_sb("t3_drain", 30);
    check("t3_timeout_latency", last_done() - t0, 9);
    check("t3_err_cnt", err_cnt[2], 1);
    check("t3_done_cnt", done_cnt[2], 2);
    check("t3_data2", ch_data[2*DW +: DW], 32'h0);
    resp_lat = 0; resp_base = 32'h3000;
    ch_req = 4'b0100;
    exp_q.push_back(4'd2);
    wait_sb("t3b_drain", 20);
    check("t3b_err_cnt", err_cnt[2], 1);
    check("t3b_data2", ch_data[2*DW +: DW], 32'h3002);

    // Data arriving on the last cycle before timeout wins.
    resp_lat = TO - 1; resp_base = 32'h4000;
    done_t.delete();
    t0 = cyc;
    ch_req = 4'b0100;
    exp_q.push_back(4'd2);
    wait_sb("t4_drain", 30);
    check("t4_latency", last_done() - t0, 9);
    check("t4_err_cnt", err_cnt[2], 1);
    check("t4_data2", ch_data[2*DW +: DW], 32'h4002);

    // Reset in the middle of a ch3 transaction.
    resp_lat = -1;
    ch_req = 4'b1000;
    tick(); tick();
    check("t5_grant_ch3", grant, 4'b1000);
    nb = total_done();
    rst = 1'b1;
    #1;
    check("t5_mem_req_drop", mem_req, 1'b0);
    check("t5_busy_drop", busy, 1'b0);
    check("t5_grant_drop", grant, 4'b0000);
    tick();
    check("t5_no_done", total_done(), nb);
    rst = 1'b0;
    resp_lat = 1; resp_base = 32'h5000;
    ch_req = 4'b1001;
    exp_q.push_back(4'd0); exp_q.push_back(4'd3);
    wait_sb("t5_drain", 30);
    check("t5_data0", ch_data[0 +: DW], 32'h5000);
    check("t5_data3", ch_data[3*DW +: DW], 32'h5003);
    check("t5_data2_cleared", ch_data[2*DW +: DW], 32'h0);

    // Request withdrawn and address changed mid-transaction, then a stray beat in IDLE.
    ch_addr[AW +: AW] = 32'h6000_0100;
    resp_lat = 4; resp_base = 32'h6000;
    ch_req = 4'b0010;
    tick();
    check("t6_mem_addr", mem_addr, 32'h6000_0100);
    ch_req[1] = 1'b0;
    ch_addr[AW +: AW] = 32'hFFFF_0000;
    exp_q.push_back(4'd1);
    wait_sb("t6_drain", 30);
    check("t6_mem_addr_held", mem_addr, 32'h6000_0100);
    check("t6_done_cnt", done_cnt[1], 2);
    check("t6_data1", ch_data[DW +: DW], 32'h6001);
    resp_mode = 3;
    nb = total_done();
    mem_valid = 1'b1; mem_data = 32'hBAD0_BAD0;
    tick();
    mem_valid = 1'b0;
    tick(); tick();
    check("t6_stray_no_done", total_done(), nb);
    check("t6_stray_data", ch_data, {32'h5003, 32'h0, 32'h6001, 32'h5000});

    // Randomized clients, memory and occasional resets.
    resp_mode = 2; client_mode = 2;
    for (int p = 0; p < 3; p++) begin
      vprob = vp[p];
      repeat (1200) tick();
    end
    client_mode = 0; rst = 1'b0; ch_req = '0; vprob = 50;
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
